axi_bridge: RTL

//  Responder for the cache-side refill/writeback interface (rd_req/rd_rdy/ret_*, wr_req/wr_rdy) that icache and dcache drive.

---
 rtl/axi_bridge.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_bridge.sv
// axi_bridge: turns icache/dcache refill and writeback requests into AXI3
// master transactions. Two read clients (icache id 0, dcache id 1) share a
// single AR register; one dcache write client drives AW/W/B through a small FSM.
// Optional feature macro: WR_RAW_CHECK_EN -- refuse reads that hit the 16-byte
// block of a write still in flight.
module axi_bridge #(
  parameter int LINE_WORDS = 4,
  parameter int AXI_ID_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  // icache read client
  input  logic                     i_rd_req,
  input  logic [2:0]               i_rd_type,
  input  logic [31:0]              i_rd_addr,
  output logic                     i_rd_rdy,
  output logic                     i_ret_valid,
  output logic                     i_ret_last,
  output logic [31:0]              i_ret_data,
  // dcache read client
  input  logic                     d_rd_req,
  input  logic [2:0]               d_rd_type,
  input  logic [31:0]              d_rd_addr,
  output logic                     d_rd_rdy,
  output logic                     d_ret_valid,
  output logic                     d_ret_last,
  output logic [31:0]              d_ret_data,
  // dcache write client
  input  logic                     d_wr_req,
  input  logic [2:0]               d_wr_type,
  input  logic [31:0]              d_wr_addr,
  input  logic [3:0]               d_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] d_wr_data,
  output logic                     d_wr_rdy,
  // AXI read address
  output logic [AXI_ID_W-1:0]      arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  // AXI read data
  input  logic [AXI_ID_W-1:0]      rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // AXI write address
  output logic [AXI_ID_W-1:0]      awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  // AXI write data
  output logic [AXI_ID_W-1:0]      wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  // AXI write response
  input  logic [AXI_ID_W-1:0]      bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int DW = 32 * LINE_WORDS;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [AXI_ID_W-1:0] ID_I = AXI_ID_W'(0);
  localparam logic [AXI_ID_W-1:0] ID_D = AXI_ID_W'(1);

  function automatic logic [7:0] enc_len(input logic [2:0] t);
    return (t == 3'b100) ? 8'(LINE_WORDS - 1) : 8'd0;
  endfunction

  function automatic logic [2:0] enc_size(input logic [2:0] t);
    return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  logic          live;
  logic          out_i, out_d;
  logic          r_fire, i_done, d_done, i_busy, d_busy;
  logic          raw_i, raw_d;
  logic          i_can, d_can, acc_i, acc_d;
  logic [1:0]    w_state;
  logic [DW-1:0] w_buf;
  logic [3:0]    w_strb_q;
  logic [7:0]    w_cnt;
  logic          unused_ok;

  assign unused_ok = ^{rresp, bid, bresp};

  // Constant AXI attributes
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'h0;
  assign awid    = ID_D;
  assign wid     = ID_D;

  // Bridge comes alive one cycle after reset; gates all ready outputs
  always_ff @(posedge clock) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end

  assign rready = live;

  // R routing: beats only reach a client that actually has a read outstanding
  assign r_fire      = rvalid & rready;
  assign i_ret_valid = r_fire & (rid == ID_I) & out_i;
  assign d_ret_valid = r_fire & (rid == ID_D) & out_d;
  assign i_ret_last  = rlast;
  assign d_ret_last  = rlast;
  assign i_ret_data  = rdata;
  assign d_ret_data  = rdata;
  assign i_done      = i_ret_valid & rlast;
  assign d_done      = d_ret_valid & rlast;
  // A client finishing on this beat counts as free, allowing same-cycle re-accept
  assign i_busy      = out_i & ~i_done;
  assign d_busy      = out_d & ~d_done;

`ifdef WR_RAW_CHECK_EN
  assign raw_i = (w_state != W_IDLE) && (i_rd_addr[31:4] == awaddr[31:4]);
  assign raw_d = (w_state != W_IDLE) && (d_rd_addr[31:4] == awaddr[31:4]);
`else
  assign raw_i = 1'b0;
  assign raw_d = 1'b0;
`endif

  // dcache wins a tie; icache only loses when dcache is both asking and eligible
  assign d_can    = live & ~arvalid & ~d_busy & ~raw_d;
  assign i_can    = live & ~arvalid & ~i_busy & ~raw_i;
  assign d_rd_rdy = d_can;
  assign i_rd_rdy = i_can & ~(d_rd_req & d_can);
  assign acc_d    = d_rd_req & d_rd_rdy;
  assign acc_i    = i_rd_req & i_rd_rdy;

  // Single AR register: loaded on accept, held until arready
  always_ff @(posedge clock) begin
    if (reset) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
    end else if (acc_d || acc_i) begin
      arvalid <= 1'b1;
      arid    <= acc_d ? ID_D : ID_I;
      araddr  <= acc_d ? d_rd_addr : i_rd_addr;
      arlen   <= enc_len(acc_d ? d_rd_type : i_rd_type);
      arsize  <= enc_size(acc_d ? d_rd_type : i_rd_type);
    end else if (arvalid && arready) begin
      arvalid <= 1'b0;
    end
  end

  // Per-client outstanding flags: set on accept, cleared on the rlast beat
  always_ff @(posedge clock) begin
    if (reset) begin
      out_i <= 1'b0;
      out_d <= 1'b0;
    end else begin
      out_i <= i_busy | acc_i;
      out_d <= d_busy | acc_d;
    end
  end

  assign d_wr_rdy = live & (w_state == W_IDLE);
  assign awvalid  = (w_state == W_AW);
  assign wvalid   = (w_state == W_DATA);
  assign bready   = (w_state == W_RESP);
  assign wdata    = w_buf[31:0];
  assign wstrb    = w_strb_q;
  assign wlast    = wvalid & (w_cnt == awlen);

  // Write FSM: capture on accept, issue AW, stream beats word0 first, await B
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state  <= W_IDLE;
      awaddr   <= '0;
      awlen    <= '0;
      awsize   <= '0;
      w_buf    <= '0;
      w_strb_q <= '0;
      w_cnt    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (d_wr_req && d_wr_rdy) begin
            w_state  <= W_AW;
            awaddr   <= d_wr_addr;
            awlen    <= enc_len(d_wr_type);
            awsize   <= enc_size(d_wr_type);
            w_strb_q <= (d_wr_type == 3'b100) ? 4'hF : d_wr_wstrb;
            w_buf    <= d_wr_data;
            w_cnt    <= '0;
          end
        end
        W_AW: begin
          if (awready) w_state <= W_DATA;
        end
        W_DATA: begin
          if (wready) begin
            w_buf <= w_buf >> 32;
            w_cnt <= w_cnt + 8'd1;
            if (wlast) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule
